// File: rtl/pulse_hist_if.sv
// Event stream and system-bus bundle for the pulse histogrammer.
// The slave modport is the histogrammer; the master is the event source plus bus host.
interface pulse_hist_if;
  logic        evt_valid_i;
  logic        evt_ready_o;
  logic        evt_type_i;
  logic [13:0] evt_amp_i;
  logic [15:0] evt_t1_i;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output evt_valid_i, evt_type_i, evt_amp_i, evt_t1_i,
    output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    input  evt_ready_o, sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  evt_valid_i, evt_type_i, evt_amp_i, evt_t1_i,
    input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    output evt_ready_o, sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/pulse_hist.sv
// Per-type amplitude histogrammer: 2-stage read-modify-write on RAM port A,
// bus bin reads on port B, plus saturating underflow/overflow/total statistics.
module pulse_hist #(
  parameter int BIN_BITS = 10,
  parameter int CNT_W    = 32
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  pulse_hist_if.slave  bus
);
  localparam int AW    = BIN_BITS + 1;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_DRAIN} state_t;

  state_t r_state, w_next;
  logic [AW-1:0] r_clr_addr;
  logic w_ready, w_zero_stats;

  // configuration
  logic             r_en, r_zfilt;
  logic [2:0]       r_shift;
  logic [1:0][13:0] r_off;
  logic [1:0]       r_inv;

  // statistics
  logic [1:0][15:0] r_unf, r_ovf;
  logic [31:0]      r_total;

  // pipeline
  logic [2:1]       r_vld_pipe;
  logic [AW-1:0]    r_s1_bin, r_s2_bin;
  logic             r_fwd;
  logic [CNT_W-1:0] r_fwd_dat, r_rda, r_rdb;
  logic [CNT_W-1:0] r_mem [DEPTH];

  // bus
  logic        r_ack, r_bq;
  logic [31:0] r_rdata;

  // ---------------- bus decode ----------------
  logic [19:0]   w_addr;
  logic          w_en, w_reg_rd, w_bin_rd, w_clr_cmd;
  logic [AW-1:0] w_b_addr;
  logic [31:0]   w_reg_rdata;
  logic          w_unused;

  assign w_addr    = bus.sys_addr[19:0];
  assign w_en      = bus.sys_wen | bus.sys_ren;
  assign w_reg_rd  = bus.sys_ren & ~bus.sys_wen;
  assign w_bin_rd  = w_reg_rd && (w_addr[19:18] == 2'b01) &&
                     ({16'd0, w_addr[17:2]} < 32'(DEPTH));
  assign w_b_addr  = w_addr[AW+1:2];
  assign w_clr_cmd = bus.sys_wen && (w_addr == 20'h0) && bus.sys_wdata[8];
  assign w_unused  = ^{bus.sys_sel, bus.sys_addr[31:20], bus.sys_addr[1:0],
                       bus.sys_wdata[31], bus.sys_wdata[15]};

  always_comb begin
    w_reg_rdata = '0;
    case (w_addr)
      20'h00000: w_reg_rdata = {25'd0, r_shift, 2'b00, r_zfilt, r_en};
      20'h00004: w_reg_rdata = {1'b0, r_inv[1], r_off[1], 1'b0, r_inv[0], r_off[0]};
      20'h00008: w_reg_rdata = {30'd0, |r_vld_pipe, (r_state != S_RUN)};
      20'h0000C: w_reg_rdata = {r_unf[1], r_unf[0]};
      20'h00010: w_reg_rdata = {r_ovf[1], r_ovf[0]};
      20'h00014: w_reg_rdata = r_total;
      20'h00018: w_reg_rdata = {16'd0, 8'(BIN_BITS), 8'(CNT_W)};
      default:   w_reg_rdata = '0;
    endcase
  end

  // The host is expected to keep one transaction outstanding; a bin read's
  // delayed completion takes the ack slot if a request lands right behind it.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_ack <= 1'b0; r_rdata <= '0; r_bq <= 1'b0;
    end else begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_bq    <= w_bin_rd;
      if (r_bq) begin
        r_ack   <= 1'b1;
        r_rdata <= 32'(r_rdb);
      end else if (w_en && !w_bin_rd) begin
        r_ack <= 1'b1;
        if (w_reg_rd) r_rdata <= w_reg_rdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_en <= 1'b0; r_zfilt <= 1'b0; r_shift <= '0; r_off <= '0; r_inv <= '0;
    end else if (bus.sys_wen) begin
      if (w_addr == 20'h0) begin
        r_en    <= bus.sys_wdata[0];
        r_zfilt <= bus.sys_wdata[1];
        r_shift <= (bus.sys_wdata[6:4] > 3'd4) ? 3'd4 : bus.sys_wdata[6:4];
      end
      if (w_addr == 20'h4) begin
        r_off[0] <= bus.sys_wdata[13:0];
        r_inv[0] <= bus.sys_wdata[14];
        r_off[1] <= bus.sys_wdata[29:16];
        r_inv[1] <= bus.sys_wdata[30];
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= S_CLEAR; r_clr_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CLEAR && !w_clr_cmd) r_clr_addr <= r_clr_addr + 1'b1;
      else                                  r_clr_addr <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    w_zero_stats = 1'b0;
    case (r_state)
      S_CLEAR: if (!w_clr_cmd && r_clr_addr == {AW{1'b1}}) w_next = S_RUN;
      S_RUN: begin
        w_ready = 1'b1;
        if (w_clr_cmd) w_next = S_DRAIN;
      end
      S_DRAIN: if (r_vld_pipe == '0) begin
        w_next       = S_CLEAR;
        w_zero_stats = 1'b1;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  // ---------------- binning (acceptance cycle) ----------------
  logic          w_acc, w_typ, w_drop, w_cnt, w_neg, w_ovf, w_hit;
  logic [14:0]   w_amp15, w_amp_n;
  logic [15:0]   w_d, w_dsh;
  logic [AW-1:0] w_bin;

  assign w_acc   = bus.evt_valid_i & w_ready;
  assign w_typ   = bus.evt_type_i;
  assign w_amp15 = {bus.evt_amp_i[13], bus.evt_amp_i};
  assign w_amp_n = r_inv[w_typ] ? (~w_amp15 + 15'd1) : w_amp15;
  assign w_d     = {w_amp_n[14], w_amp_n} - {{2{r_off[w_typ][13]}}, r_off[w_typ]};
  assign w_dsh   = w_d >> r_shift;
  assign w_neg   = w_d[15];
  assign w_ovf   = |w_dsh[15:BIN_BITS];
  assign w_bin   = {w_typ, w_dsh[BIN_BITS-1:0]};
  assign w_drop  = !r_en || (r_zfilt && bus.evt_t1_i == 16'd0);
  assign w_cnt   = w_acc && !w_drop;
  assign w_hit   = w_cnt && !w_neg && !w_ovf;

  always_ff @(posedge clk_i) begin
    if (!rstn_i || w_zero_stats) begin
      r_unf <= '0; r_ovf <= '0; r_total <= '0;
    end else if (w_cnt) begin
      if (r_total != '1) r_total <= r_total + 32'd1;
      if (w_neg) begin
        if (r_unf[w_typ] != '1) r_unf[w_typ] <= r_unf[w_typ] + 16'd1;
      end else if (w_ovf) begin
        if (r_ovf[w_typ] != '1) r_ovf[w_typ] <= r_ovf[w_typ] + 16'd1;
      end
    end
  end

  // ---------------- RMW pipeline ----------------
  logic [CNT_W-1:0] w_rd, w_wdata, w_a_wdat;
  logic [AW-1:0]    w_a_waddr;
  logic             w_a_we;

  // RAM is read-first, so a stage-2 write to the bin just read is forwarded
  assign w_rd      = r_fwd ? r_fwd_dat : r_rda;
  assign w_wdata   = (&w_rd) ? w_rd : w_rd + CNT_W'(1);
  assign w_a_we    = (r_state == S_CLEAR) | r_vld_pipe[2];
  assign w_a_waddr = (r_state == S_CLEAR) ? r_clr_addr : r_s2_bin;
  assign w_a_wdat  = (r_state == S_CLEAR) ? '0 : w_wdata;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_vld_pipe <= '0; r_s1_bin <= '0; r_s2_bin <= '0;
      r_fwd <= 1'b0; r_fwd_dat <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], w_hit};
      if (w_hit) r_s1_bin <= w_bin;
      r_s2_bin  <= r_s1_bin;
      r_fwd     <= r_vld_pipe[2] && r_vld_pipe[1] && (r_s2_bin == r_s1_bin);
      r_fwd_dat <= w_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_a_we) r_mem[w_a_waddr] <= w_a_wdat;
    r_rda <= r_mem[r_s1_bin];
    r_rdb <= r_mem[w_b_addr];
  end

  assign bus.evt_ready_o = w_ready;
  assign bus.sys_ack     = r_ack;
  assign bus.sys_rdata   = r_rdata;
  assign bus.sys_err     = 1'b0;
endmodule
